// File: rtl/multicycle_mips_core.sv
// Multicycle MIPS subset core (lw, sw, add/sub/and/or/slt, beq, addi, j) on a
// unified memory port with a req/ready handshake; unsupported opcodes park the core.
module multicycle_mips_core #(
    parameter int                    datasize = 32,
    parameter logic [datasize-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    output logic [datasize-1:0] mem_addr,
    output logic [datasize-1:0] mem_wdata,
    input  logic [datasize-1:0] mem_rdata,
    output logic                mem_req,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic [datasize-1:0] Pc,
    output logic                illegal,
    output logic [3:0]          state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        ILLEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t              state, next_state;
    logic [datasize-1:0] ir, mdr, a_reg, b_reg, alu_out;
    logic [datasize-1:0] rf [0:31];

    logic [5:0]          opcode, funct;
    logic [4:0]          rs, rt, rd;
    logic [datasize-1:0] sext_imm, rs_val, rt_val;
    logic [datasize-1:0] alu_result;
    logic                funct_ok;

    logic                req_int;
    logic                ir_en, pc_en, ab_en, alu_en, mdr_en, rf_we;
    logic [datasize-1:0] pc_next, alu_next, rf_wdata;
    logic [4:0]          rf_waddr;
    logic                unused_shamt;

    assign opcode       = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign unused_shamt = ^ir[10:6];
    assign sext_imm     = {{(datasize-16){ir[15]}}, ir[15:0]};

    assign rs_val = (rs == 5'd0) ? '0 : rf[rs];
    assign rt_val = (rt == 5'd0) ? '0 : rf[rt];

    always_comb begin
        alu_result = '0;
        funct_ok   = 1'b1;
        case (funct)
            6'h20:   alu_result = a_reg + b_reg;
            6'h22:   alu_result = a_reg - b_reg;
            6'h24:   alu_result = a_reg & b_reg;
            6'h25:   alu_result = a_reg | b_reg;
            6'h2A:   alu_result = {{(datasize-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
            default: funct_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_int    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = Pc;
        mem_wdata  = b_reg;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        pc_next    = Pc;
        ab_en      = 1'b0;
        alu_en     = 1'b0;
        alu_next   = alu_out;
        mdr_en     = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = rt;
        rf_wdata   = alu_out;
        case (state)
            FETCH: begin
                req_int = 1'b1;
                if (mem_ready) begin
                    ir_en      = 1'b1;
                    pc_en      = 1'b1;
                    pc_next    = Pc + datasize'(4);
                    next_state = DECODE;
                end
            end
            DECODE: begin
                // Branch target is precomputed here so BRANCH only compares.
                ab_en    = 1'b1;
                alu_en   = 1'b1;
                alu_next = Pc + (sext_imm << 2);
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_en     = 1'b1;
                alu_next   = a_reg + sext_imm;
                next_state = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                req_int  = 1'b1;
                mem_addr = alu_out;
                if (mem_ready) begin
                    mdr_en     = 1'b1;
                    next_state = MEMWB;
                end
            end
            MEMWB: begin
                rf_we      = 1'b1;
                rf_waddr   = rt;
                rf_wdata   = mdr;
                next_state = FETCH;
            end
            MEMWRITE: begin
                req_int  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = alu_out;
                if (mem_ready) next_state = FETCH;
            end
            EXECUTE: begin
                if (funct_ok) begin
                    alu_en     = 1'b1;
                    alu_next   = alu_result;
                    next_state = ALUWB;
                end else begin
                    next_state = ILLEGAL;
                end
            end
            ALUWB: begin
                rf_we      = 1'b1;
                rf_waddr   = rd;
                next_state = FETCH;
            end
            BRANCH: begin
                if (a_reg == b_reg) begin
                    pc_en   = 1'b1;
                    pc_next = alu_out;
                end
                next_state = FETCH;
            end
            ADDIEX: begin
                alu_en     = 1'b1;
                alu_next   = a_reg + sext_imm;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                rf_we      = 1'b1;
                rf_waddr   = rt;
                next_state = FETCH;
            end
            JUMP: begin
                pc_en      = 1'b1;
                pc_next    = {Pc[31:28], ir[25:0], 2'b00};
                next_state = FETCH;
            end
            ILLEGAL: next_state = ILLEGAL;
            default: next_state = FETCH;
        endcase
    end

    // Gating with reset keeps the port quiet while reset is held, even in FETCH.
    assign mem_req   = req_int & reset;
    assign illegal   = (state == ILLEGAL);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            if (pc_en)  Pc      <= pc_next;
            if (ir_en)  ir      <= mem_rdata;
            if (mdr_en) mdr     <= mem_rdata;
            if (alu_en) alu_out <= alu_next;
            if (ab_en) begin
                a_reg <= rs_val;
                b_reg <= rt_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Bench for multicycle_mips_core: behavioural memory with controllable ready,
// store scoreboard, and directed/random programs.
module tb_multicycle_mips_core;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_ILLEGAL  = 4'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, Pc;
    logic        mem_req, mem_we, illegal;
    logic        mem_ready = 1'b1;
    logic [3:0]  state_dbg;

    logic [31:0] mem [0:63];
    logic        force_low = 1'b0;
    logic        rand_ready = 1'b0;
    int          cyc;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          got_cyc_q[$];

    multicycle_mips_core #(.datasize(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ready(mem_ready), .Pc(Pc), .illegal(illegal), .state_dbg(state_dbg)
    );

    // clock / reset-relative cycle counter
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // memory model: ready chosen on the falling edge, write recorded if the next rising edge completes it
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(negedge clk) begin
        if (force_low)       mem_ready = 1'b0;
        else if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
        else                 mem_ready = 1'b1;
        if (reset && mem_req && mem_we && mem_ready) begin
            got_q.push_back({mem_addr, mem_wdata});
            got_cyc_q.push_back(cyc);
            mem[mem_addr[7:2]] = mem_wdata;
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        force_low = 1'b0;
        rand_ready = 1'b0;
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
        repeat (2) tick();
        clear_mem();
    endtask

    task automatic wait_writes(input int count, input int limit);
        int n;
        n = 0;
        while (got_q.size() < count && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (got_q.size() < count) begin
            errors++;
            $display("FAIL write_timeout: got %0d writes, need %0d", got_q.size(), count);
        end
    endtask

    // scenarios
    task automatic test_reset();
        hold_reset();
        mem[0] = 32'h0800_0010;
        mem[16] = 32'h0800_0010;
        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req_async: got %b need 0", mem_req); end
        checks++; if (Pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h need 00000000", Pc); end
        checks++; if (state_dbg !== S_FETCH) begin errors++; $display("FAIL reset_state: got %0d need %0d", state_dbg, S_FETCH); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b need 0", illegal); end
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req_held: got %b need 0", mem_req); end
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_fetch_req: got %b need 1", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL first_fetch_addr: got %h need 00000000", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL first_fetch_we: got %b need 0", mem_we); end
    endtask

    task automatic test_store_program();
        logic [63:0] g, e;
        int          c;
        hold_reset();
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h0021_1020;
        mem[2] = 32'hAC02_0000;
        mem[3] = 32'h0800_0003;
        exp_q.push_back({32'h0, 32'h0000_000A});
        reset = 1'b1;
        wait_writes(1, 60);
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            c = got_cyc_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL store_prog_write: got %h need %h", g, e); end
            checks++; if (c !== 4 + 4 + 4 - 1) begin errors++; $display("FAIL store_prog_cycle: got %0d need %0d", c, 11); end
        end
        repeat (20) tick();
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL store_prog_extra: got %0d extra writes need 0", got_q.size()); end
    endtask

    task automatic test_fetch_wait();
        hold_reset();
        mem[0] = 32'h2001_0005;
        force_low = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (state_dbg !== S_FETCH || mem_addr !== 32'h0 || Pc !== 32'h0 || mem_req !== 1'b1) begin
                errors++;
                $display("FAIL fetch_wait_%0d: got state=%0d addr=%h pc=%h req=%b need 0/0/0/1", k, state_dbg, mem_addr, Pc, mem_req);
            end
            if (k == 2) force_low = 1'b0;
            tick();
        end
        tick();
        checks++; if (state_dbg !== S_DECODE) begin errors++; $display("FAIL fetch_done_state: got %0d need %0d", state_dbg, S_DECODE); end
        checks++; if (Pc !== 32'h4) begin errors++; $display("FAIL fetch_done_pc: got %h need 00000004", Pc); end
    endtask

    task automatic test_branch_jump();
        hold_reset();
        mem[0] = 32'h2000_0000;
        mem[1] = 32'h2000_0000;
        mem[2] = 32'h1000_FFFF;
        reset = 1'b1;
        repeat (10) tick();
        checks++; if (state_dbg !== S_BRANCH || Pc !== 32'hC) begin errors++; $display("FAIL beq_state: got %0d pc=%h need %0d pc=0000000c", state_dbg, Pc, S_BRANCH); end
        tick();
        checks++; if (Pc !== 32'h8 || mem_addr !== 32'h8) begin errors++; $display("FAIL beq_taken: got pc=%h addr=%h need 00000008", Pc, mem_addr); end
        tick();
        checks++; if (Pc !== 32'hC) begin errors++; $display("FAIL beq_refetch: got %h need 0000000c", Pc); end
        repeat (2) tick();
        checks++; if (Pc !== 32'h8) begin errors++; $display("FAIL beq_repeat: got %h need 00000008", Pc); end

        hold_reset();
        mem[0] = 32'h0800_0010;
        mem[16] = 32'h0800_0010;
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (state_dbg !== S_JUMP) begin errors++; $display("FAIL j_state: got %0d need %0d", state_dbg, S_JUMP); end
        tick();
        checks++; if (Pc !== 32'h40 || mem_addr !== 32'h40) begin errors++; $display("FAIL j_target: got pc=%h addr=%h need 00000040", Pc, mem_addr); end
    endtask

    task automatic test_illegal();
        hold_reset();
        mem[0] = 32'hFC00_0000;
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (illegal !== 1'b1 || mem_req !== 1'b0 || state_dbg !== S_ILLEGAL) begin errors++; $display("FAIL illegal_op: got ill=%b req=%b state=%0d need 1/0/%0d", illegal, mem_req, state_dbg, S_ILLEGAL); end
        repeat (6) tick();
        checks++; if (illegal !== 1'b1 || mem_req !== 1'b0 || Pc !== 32'h4) begin errors++; $display("FAIL illegal_sticky: got ill=%b req=%b pc=%h need 1/0/00000004", illegal, mem_req, Pc); end
        reset = 1'b0;
        #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_cleared: got %b need 0", illegal); end

        hold_reset();
        mem[0] = 32'h0000_003F;
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL funct_early: got %b need 0", illegal); end
        tick();
        checks++; if (illegal !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL funct_illegal: got ill=%b req=%b need 1/0", illegal, mem_req); end
        repeat (5) tick();
        checks++; if (illegal !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL funct_sticky: got ill=%b req=%b need 1/0", illegal, mem_req); end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] g, e;
        int          c;
        hold_reset();
        mem[0] = 32'h2001_0007;
        mem[1] = 32'hAC01_0010;
        mem[2] = 32'h0800_0002;
        reset = 1'b1;
        repeat (6) tick();
        force_low = 1'b1;
        tick();
        checks++; if (state_dbg !== S_MEMWRITE || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'h7) begin
            errors++; $display("FAIL sw_wait_pins: got st=%0d req=%b we=%b addr=%h data=%h need 5/1/1/00000010/00000007", state_dbg, mem_req, mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if (state_dbg !== S_MEMWRITE || mem_addr !== 32'h10) begin errors++; $display("FAIL sw_wait_hold: got st=%0d addr=%h need 5/00000010", state_dbg, mem_addr); end
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || state_dbg !== S_FETCH || Pc !== 32'h0) begin errors++; $display("FAIL abort_reset: got req=%b st=%0d pc=%h need 0/0/00000000", mem_req, state_dbg, Pc); end
        force_low = 1'b0;
        tick();
        checks++; if (got_q.size() !== 0 || mem[4] !== 32'h0) begin errors++; $display("FAIL abort_no_write: got %0d writes mem=%h need 0/00000000", got_q.size(), mem[4]); end
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL refetch: got req=%b addr=%h need 1/00000000", mem_req, mem_addr); end
        exp_q.push_back({32'h10, 32'h7});
        wait_writes(1, 40);
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            c = got_cyc_q.pop_front();
            checks++; if (g !== e || c !== 7) begin errors++; $display("FAIL rerun_write: got %h@%0d need %h@7", g, c, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, r3, r4, r5, r6, r7, r8;
        logic [63:0] g, e;
        hold_reset();
        d  = 32'h1234_5678;
        r3 = d - 32'd1;
        r4 = r3 - d;
        r5 = ($signed(r4) < $signed(d)) ? 32'd1 : 32'd0;
        r6 = d & r3;
        r7 = r5 | r6;
        r8 = ($signed(d) < $signed(r4)) ? 32'd1 : 32'd0;
        mem[0]  = 32'h8C02_0040;
        mem[1]  = 32'h2043_FFFF;
        mem[2]  = 32'h0062_2022;
        mem[3]  = 32'h0082_282A;
        mem[4]  = 32'h0043_3024;
        mem[5]  = 32'h00A6_3825;
        mem[6]  = 32'hAC04_0080;
        mem[7]  = 32'hAC05_0084;
        mem[8]  = 32'hAC07_0088;
        mem[9]  = 32'h0044_402A;
        mem[10] = 32'hAC08_008C;
        mem[11] = 32'h0042_0020;
        mem[12] = 32'hAC00_0090;
        mem[13] = 32'h0800_000D;
        mem[16] = d;
        exp_q.push_back({32'h80, r4});
        exp_q.push_back({32'h84, r5});
        exp_q.push_back({32'h88, r7});
        exp_q.push_back({32'h8C, r8});
        exp_q.push_back({32'h90, 32'h0});
        rand_ready = 1'b1;
        reset = 1'b1;
        wait_writes(5, 3000);
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL b2b_write_%0d: got none need %h", i, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL b2b_write_%0d: got %h need %h", i, g, e); end
            end
        end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL b2b_illegal: got %b need 0", illegal); end
    endtask

    // sequence and report
    initial begin
        clear_mem();
        test_reset();
        test_store_program();
        test_fetch_wait();
        test_branch_jump();
        test_illegal();
        test_reset_mid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
